instr_mem_loader: RTL and testbench

Parametrised, loadable instruction memory for the MIPS32 fetch stage. It holds a word-addressed program store that is zero-filled after reset and written through a streaming load port. Reads are served through a pipelined fetch handshake with configurable read latency, and misaligned or out-of-range fetches are flagged. It sits between the PC logic and the decode stage.

---
 rtl/instr_mem_pkg.sv | 20 ++
 rtl/instr_mem_loader_if.sv | 36 +++
 rtl/instr_mem_pipe.sv | 50 +++++
 rtl/instr_mem_loader.sv | 130 +++++++++++++
 tb/tb_instr_mem_loader.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_pkg
// Brief    : Shared types and constants for the loadable instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
package instr_mem_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    localparam logic [31:0] c_NOP              = 32'h0000_0000;
    localparam int          c_READ_LATENCY_MIN = 1;
    localparam int          c_READ_LATENCY_MAX = 4;

endpackage
`default_nettype wire

// File: rtl/instr_mem_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_loader_if
// Brief    : Load-stream and fetch-handshake bundle of the instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_mem_loader_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  load_start;
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_last;
    logic                  load_ready;
    logic                  load_overflow;
    logic                  fetch_req;
    logic [31:0]           fetch_addr;
    logic                  fetch_ready;
    logic                  instr_valid;
    logic [DATA_WIDTH-1:0] instruction;
    logic                  fetch_err;
    logic                  busy;

    modport master (
        output load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
        input  load_ready, load_overflow, fetch_ready, instr_valid, instruction,
               fetch_err, busy
    );

    modport slave (
        input  load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
        output load_ready, load_overflow, fetch_ready, instr_valid, instruction,
               fetch_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/instr_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_pipe
// Brief    : Fixed-depth read pipeline carrying {valid, err, data}.
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_valid,
    input  wire logic                  i_err,
    input  wire logic [DATA_WIDTH-1:0] i_data,
    output logic                       o_valid,
    output logic                       o_err,
    output logic [DATA_WIDTH-1:0]      o_data
);
    logic [READ_LATENCY-1:0] r_valid;
    logic [READ_LATENCY-1:0] r_err;
    logic [DATA_WIDTH-1:0]   r_data [READ_LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            r_valid[0] <= i_valid;
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_valid[k] <= r_valid[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_err[0]  <= i_err;
        r_data[0] <= i_data;
        for (int k = 1; k < READ_LATENCY; k++) begin
            r_err[k]  <= r_err[k-1];
            r_data[k] <= r_data[k-1];
        end
    end

    // Payload registers carry no reset; qualifying by valid keeps outputs at zero.
    assign o_valid = r_valid[READ_LATENCY-1];
    assign o_err   = r_valid[READ_LATENCY-1] & r_err[READ_LATENCY-1];
    assign o_data  = r_valid[READ_LATENCY-1] ? r_data[READ_LATENCY-1] : '0;

endmodule
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_loader
// Brief    : Zero-cleared, stream-loadable instruction store with pipelined fetch.
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_loader
    import instr_mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    instr_mem_loader_if.slave bus
);
    localparam int c_DEPTH   = 2 ** ADDR_WIDTH;
    // Out-of-range latencies are pinned to the nearest legal depth.
    localparam int c_LATENCY = (READ_LATENCY < c_READ_LATENCY_MIN) ? c_READ_LATENCY_MIN :
                               (READ_LATENCY > c_READ_LATENCY_MAX) ? c_READ_LATENCY_MAX :
                               READ_LATENCY;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_ptr;
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   w_wr_idx;
    logic                  r_overflow;
    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    logic                  w_fetch_ready;
    logic                  w_load_word;
    logic                  w_load_full;
    logic                  w_accept;
    logic                  w_err;
    logic [ADDR_WIDTH-1:0] w_rd_idx;
    logic [DATA_WIDTH-1:0] w_rd_data;

    always_comb begin
        w_state_nxt   = r_state;
        w_fetch_ready = 1'b0;
        w_load_word   = 1'b0;
        w_wr_idx      = r_wr_ptr;
        case (r_state)
            ST_CLEAR: begin
                if (r_clr_ptr == {ADDR_WIDTH{1'b1}}) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                w_fetch_ready = ~bus.load_start;
                if (bus.load_start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // A restart lands its own word at index 0.
                if (bus.load_start) begin
                    w_wr_idx = '0;
                end
                w_load_word = bus.load_valid;
                if (bus.load_valid && bus.load_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_CLEAR;
        endcase
        w_load_full = (w_wr_idx == (ADDR_WIDTH+1)'(c_DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_CLEAR;
            r_clr_ptr  <= '0;
            r_wr_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_CLEAR) begin
                r_clr_ptr <= r_clr_ptr + 1'b1;
            end
            if (bus.load_start && (r_state != ST_CLEAR)) begin
                r_wr_ptr   <= '0;
                r_overflow <= 1'b0;
            end
            if (w_load_word) begin
                if (w_load_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_wr_ptr <= w_wr_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_clr_ptr] <= DATA_WIDTH'(c_NOP);
        end else if (w_load_word && !w_load_full) begin
            r_mem[w_wr_idx[ADDR_WIDTH-1:0]] <= bus.load_data;
        end
    end

    assign w_accept  = bus.fetch_req & w_fetch_ready;
    assign w_rd_idx  = bus.fetch_addr[ADDR_WIDTH+1:2];
    assign w_err     = (|bus.fetch_addr[1:0]) | (|(bus.fetch_addr >> (ADDR_WIDTH + 2)));
    assign w_rd_data = w_err ? DATA_WIDTH'(c_NOP) : r_mem[w_rd_idx];

    instr_mem_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (c_LATENCY)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_accept),
        .i_err   (w_err),
        .i_data  (w_rd_data),
        .o_valid (bus.instr_valid),
        .o_err   (bus.fetch_err),
        .o_data  (bus.instruction)
    );

    assign bus.load_ready    = (r_state == ST_LOAD);
    assign bus.load_overflow = r_overflow;
    assign bus.fetch_ready   = w_fetch_ready;
    assign bus.busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem_loader
// Brief    : Scoreboard bench: large instance (AW=8, RL=2), small one (AW=2, RL=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loader;
    localparam int c_AW_B = 8;
    localparam int c_RL_B = 2;
    localparam int c_AW_S = 2;
    localparam int c_RL_S = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned r_cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int unsigned cyc;
    } exp_t;

    exp_t        q_b [$];
    exp_t        q_s [$];
    logic [31:0] m_b [2**c_AW_B];
    logic [31:0] m_s [2**c_AW_S];
    int          wp_b = 0;
    int          wp_s = 0;

    instr_mem_loader_if #(.DATA_WIDTH(32)) bus_b ();
    instr_mem_loader_if #(.DATA_WIDTH(32)) bus_s ();

    instr_mem_loader #(.ADDR_WIDTH(c_AW_B), .DATA_WIDTH(32), .READ_LATENCY(c_RL_B)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b.slave)
    );
    instr_mem_loader #(.ADDR_WIDTH(c_AW_S), .DATA_WIDTH(32), .READ_LATENCY(c_RL_S)) dut_s (
        .clk (clk), .rst (rst), .bus (bus_s.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) r_cyc <= r_cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus_b.instr_valid) begin
            if (q_b.size() == 0) check("b_unexpected_strobe", 64'd1, 64'd0);
            else begin
                e = q_b.pop_front();
                check("b_instr", 64'(bus_b.instruction), 64'(e.data));
                check("b_err", 64'(bus_b.fetch_err), 64'(e.err));
                check("b_cycle", 64'(r_cyc), 64'(e.cyc));
            end
        end
        if (!rst && bus_s.instr_valid) begin
            if (q_s.size() == 0) check("s_unexpected_strobe", 64'd1, 64'd0);
            else begin
                e = q_s.pop_front();
                check("s_instr", 64'(bus_s.instruction), 64'(e.data));
                check("s_err", 64'(bus_s.fetch_err), 64'(e.err));
                check("s_cycle", 64'(r_cyc), 64'(e.cyc));
            end
        end
    end

    function automatic logic addr_err(input logic [31:0] a, input int aw);
        return (a[1:0] != 2'b00) || ((a >> (aw + 2)) != 32'd0);
    endfunction

    // All drive tasks are entered just after a falling edge and return on the next one.
    task automatic fetch_b(input logic [31:0] addr);
        exp_t e;
        bus_b.fetch_req = 1'b1; bus_b.fetch_addr = addr; #1;
        if (bus_b.fetch_ready) begin
            e.err  = addr_err(addr, c_AW_B);
            e.data = e.err ? 32'd0 : m_b[addr[c_AW_B+1:2]];
            e.cyc  = r_cyc + c_RL_B;
            q_b.push_back(e);
        end else check("b_fetch_ready", 64'd0, 64'd1);
        @(negedge clk); bus_b.fetch_req = 1'b0;
    endtask

    task automatic fetch_s(input logic [31:0] addr);
        exp_t e;
        bus_s.fetch_req = 1'b1; bus_s.fetch_addr = addr; #1;
        if (bus_s.fetch_ready) begin
            e.err  = addr_err(addr, c_AW_S);
            e.data = e.err ? 32'd0 : m_s[addr[c_AW_S+1:2]];
            e.cyc  = r_cyc + c_RL_S;
            q_s.push_back(e);
        end else check("s_fetch_ready", 64'd0, 64'd1);
        @(negedge clk); bus_s.fetch_req = 1'b0;
    endtask

    task automatic load_start_b();
        bus_b.load_start = 1'b1; #1;
        check("b_ready_on_start", 64'(bus_b.fetch_ready), 64'd0);
        wp_b = 0;
        @(negedge clk); bus_b.load_start = 1'b0;
    endtask

    task automatic load_start_s();
        bus_s.load_start = 1'b1; #1;
        wp_s = 0;
        @(negedge clk); bus_s.load_start = 1'b0;
    endtask

    task automatic load_word_b(input logic [31:0] d, input logic last);
        bus_b.load_valid = 1'b1; bus_b.load_data = d; bus_b.load_last = last; #1;
        check("b_load_ready", 64'(bus_b.load_ready), 64'd1);
        check("b_ready_in_load", 64'(bus_b.fetch_ready), 64'd0);
        if (wp_b < 2**c_AW_B) m_b[wp_b] = d;
        wp_b++;
        @(negedge clk); bus_b.load_valid = 1'b0; bus_b.load_last = 1'b0;
    endtask

    task automatic load_word_s(input logic [31:0] d, input logic last);
        bus_s.load_valid = 1'b1; bus_s.load_data = d; bus_s.load_last = last; #1;
        check("s_load_ready", 64'(bus_s.load_ready), 64'd1);
        if (wp_s < 2**c_AW_S) m_s[wp_s] = d;
        wp_s++;
        @(negedge clk); bus_s.load_valid = 1'b0; bus_s.load_last = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q_b.size() != 0 || q_s.size() != 0) && n < 50) begin
            @(negedge clk); n++;
        end
        check("drain_b", 64'(q_b.size()), 64'd0);
        check("drain_s", 64'(q_s.size()), 64'd0);
    endtask

    task automatic check_reset_b();
        check("rst_load_ready", 64'(bus_b.load_ready), 64'd0);
        check("rst_overflow", 64'(bus_b.load_overflow), 64'd0);
        check("rst_fetch_ready", 64'(bus_b.fetch_ready), 64'd0);
        check("rst_instr_valid", 64'(bus_b.instr_valid), 64'd0);
        check("rst_instruction", 64'(bus_b.instruction), 64'd0);
        check("rst_fetch_err", 64'(bus_b.fetch_err), 64'd0);
        check("rst_busy", 64'(bus_b.busy), 64'd1);
    endtask

    task automatic wait_clear(input int exp_b, input int exp_s);
        int cnt_b = 0;
        int cnt_s = 0;
        fork
            begin
                while (!bus_b.fetch_ready && cnt_b < 2000) begin @(posedge clk); #1; cnt_b++; end
            end
            begin
                while (!bus_s.fetch_ready && cnt_s < 2000) begin @(posedge clk); #1; cnt_s++; end
            end
        join
        check("b_clear_cycles", 64'(cnt_b), 64'(exp_b));
        check("s_clear_cycles", 64'(cnt_s), 64'(exp_s));
        @(negedge clk);
    endtask

    initial begin
        bus_b.load_start = 1'b0; bus_b.load_valid = 1'b0; bus_b.load_data = '0;
        bus_b.load_last  = 1'b0; bus_b.fetch_req  = 1'b0; bus_b.fetch_addr = '0;
        bus_s.load_start = 1'b0; bus_s.load_valid = 1'b0; bus_s.load_data = '0;
        bus_s.load_last  = 1'b0; bus_s.fetch_req  = 1'b0; bus_s.fetch_addr = '0;
        foreach (m_b[i]) m_b[i] = 32'd0;
        foreach (m_s[i]) m_s[i] = 32'd0;

        repeat (3) @(negedge clk);
        check_reset_b();
        check("s_rst_busy", 64'(bus_s.busy), 64'd1);
        check("s_rst_fetch_ready", 64'(bus_s.fetch_ready), 64'd0);
        rst = 1'b0;
        wait_clear(2**c_AW_B, 2**c_AW_S);

        // Small instance: overflow, readback and overflow clear on restart.
        load_start_s();
        load_word_s(32'h11, 1'b0); load_word_s(32'h22, 1'b0); load_word_s(32'h33, 1'b0);
        load_word_s(32'h44, 1'b0); load_word_s(32'h55, 1'b1);
        check("s_overflow", 64'(bus_s.load_overflow), 64'd1);
        fetch_s(32'h0C); fetch_s(32'h10); fetch_s(32'h00);
        drain();
        load_start_s();
        check("s_overflow_cleared", 64'(bus_s.load_overflow), 64'd0);
        load_word_s(32'h66, 1'b1);
        fetch_s(32'h00);
        drain();

        // Large instance: program load, back-to-back and error fetches.
        load_start_b();
        load_word_b(32'h2008_0002, 1'b0);
        load_word_b(32'h2109_0004, 1'b0);
        load_word_b(32'h0109_5020, 1'b1);
        check("b_ready_after_load", 64'(bus_b.fetch_ready), 64'd1);
        check("b_overflow", 64'(bus_b.load_overflow), 64'd0);
        fetch_b(32'h00); fetch_b(32'h04); fetch_b(32'h08); fetch_b(32'h0C);
        fetch_b(32'h06); fetch_b(32'h400);
        drain();

        // Load/fetch collision with two fetches in flight.
        fetch_b(32'h00); fetch_b(32'h04);
        bus_b.load_start = 1'b1; bus_b.fetch_req = 1'b1; bus_b.fetch_addr = 32'h08; #1;
        check("b_collision_ready", 64'(bus_b.fetch_ready), 64'd0);
        wp_b = 0;
        @(negedge clk); bus_b.load_start = 1'b0; bus_b.fetch_req = 1'b0;
        load_word_b(32'hAAAA_0001, 1'b0);
        load_word_b(32'hAAAA_0002, 1'b1);
        fetch_b(32'h00); fetch_b(32'h04); fetch_b(32'h08);
        drain();

        // Reset in the middle of a load.
        load_start_b();
        load_word_b(32'hDEAD_0001, 1'b0);
        load_word_b(32'hDEAD_0002, 1'b0);
        bus_b.load_valid = 1'b1; bus_b.load_data = 32'hDEAD_0003;
        #2 rst = 1'b1; #1;
        check_reset_b();
        bus_b.load_valid = 1'b0;
        q_b.delete(); q_s.delete();
        foreach (m_b[i]) m_b[i] = 32'd0;
        foreach (m_s[i]) m_s[i] = 32'd0;
        @(negedge clk); rst = 1'b0;
        wait_clear(2**c_AW_B, 2**c_AW_S);
        fetch_b(32'h00); fetch_b(32'h04);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
